// File: rtl/ef_spi_target_if.sv
// ef_spi_target_if: register-side bus of the SPI target.
// Carries the FIFO access strobes, FIFO configuration, levels and status pulses.
// The master modport is the bus wrapper; the slave modport is the SPI target.
interface ef_spi_target_if #(
  parameter int FAW = 4
);
  logic           wr;
  logic [7:0]     datai;
  logic           rd;
  logic [7:0]     datao;
  logic           rx_en;
  logic           rx_flush;
  logic           tx_flush;
  logic [FAW-1:0] rx_threshold;
  logic [FAW-1:0] tx_threshold;
  logic [FAW:0]   rx_level;
  logic [FAW:0]   tx_level;
  logic           rx_above;
  logic           tx_below;
  logic           busy;
  logic           done;
  logic           rx_overflow;
  logic           tx_underrun;

  modport master (
    output wr, datai, rd, rx_en, rx_flush, tx_flush, rx_threshold, tx_threshold,
    input  datao, rx_level, tx_level, rx_above, tx_below, busy, done, rx_overflow, tx_underrun
  );

  modport slave (
    input  wr, datai, rd, rx_en, rx_flush, tx_flush, rx_threshold, tx_threshold,
    output datao, rx_level, tx_level, rx_above, tx_below, busy, done, rx_overflow, tx_underrun
  );
endinterface

// File: rtl/ef_spi_target.sv
// ef_spi_target: SPI target that oversamples sclk/csb/mosi in the clk domain.
// MSB-first 8-bit bytes, all four CPOL/CPHA modes, RX and TX FIFOs of 2^FAW bytes.
// Build option EF_SPI_TARGET_SYNC_EN: when defined, each pin gets a 2-flop
// synchronizer before the edge register; when undefined, a single capture flop
// (only for pins already synchronous to clk).
module ef_spi_target #(
  parameter int FAW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           CPOL,
  input  logic           CPHA,
  input  logic           sclk,
  input  logic           csb,
  input  logic           mosi,
  output logic           miso,
  output logic           miso_oe,
  ef_spi_target_if.slave bus
);
  localparam int             DEPTH   = 1 << FAW;
  localparam logic [FAW:0]   FULL    = {1'b1, {FAW{1'b0}}};
  localparam logic [FAW-1:0] PTR_ONE = FAW'(1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  // ---------------------------------------------------------------- input stage
  logic [2:0] pin_sync;    // {sclk, csb, mosi} as seen by the control logic
  logic [1:0] pin_prev_q;  // {sclk, csb} one cycle older, for edge detection

`ifdef EF_SPI_TARGET_SYNC_EN
  logic [2:0] pin_s1_q, pin_s2_q;
  // Two-flop synchronizer per pin, followed by the edge register.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  // The pin pipeline is not reset: it keeps tracking the pins so that leaving
  // reset with csb already low does not look like a csb fall.
  always_ff @(posedge clk) begin
    pin_s1_q   <= {sclk, csb, mosi};
    pin_s2_q   <= pin_s1_q;
    pin_prev_q <= pin_s2_q[2:1];
  end
  assign pin_sync = pin_s2_q;
`else
  logic [2:0] pin_s1_q;
  // Single capture flop per pin, followed by the edge register.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  // The pin pipeline is not reset: it keeps tracking the pins so that leaving
  // reset with csb already low does not look like a csb fall.
  always_ff @(posedge clk) begin
    pin_s1_q   <= {sclk, csb, mosi};
    pin_prev_q <= pin_s1_q[2:1];
  end
  assign pin_sync = pin_s1_q;
`endif

  logic sclk_s, csb_s, mosi_s;
  logic csb_fall, csb_rise, sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;

  assign sclk_s      = pin_sync[2];
  assign csb_s       = pin_sync[1];
  assign mosi_s      = pin_sync[0];
  assign csb_fall    = pin_prev_q[0] & ~csb_s;
  assign csb_rise    = ~pin_prev_q[0] & csb_s;
  assign sclk_edge   = pin_prev_q[1] ^ sclk_s;
  assign lead_edge   = sclk_edge & (sclk_s != CPOL);
  assign trail_edge  = sclk_edge & (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  // ---------------------------------------------------------------- state
  state_t         state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [6:0]     rx_sr_q, rx_sr_d;  // first seven bits; the eighth comes straight from mosi
  logic [7:0]     tx_sr_q, tx_sr_d;
  logic           busy_q, busy_d;
  logic           miso_oe_q, miso_oe_d;
  logic           done_q, done_d;
  logic           rx_overflow_q, rx_overflow_d;
  logic           tx_underrun_q, tx_underrun_d;

  logic [7:0]     rx_mem_q [DEPTH];
  logic [7:0]     tx_mem_q [DEPTH];
  logic [FAW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [FAW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [FAW:0]   rx_level_q, rx_level_d, tx_level_q, tx_level_d;

  logic [7:0]     rx_byte;
  logic           rx_push, tx_pop, tx_load, tx_wr_ok, rx_rd_ok;
  logic           rx_empty, rx_full, tx_empty, tx_full;

  assign rx_empty = (rx_level_q == '0);
  assign rx_full  = (rx_level_q == FULL);
  assign tx_empty = (tx_level_q == '0);
  assign tx_full  = (tx_level_q == FULL);
  assign rx_byte  = {rx_sr_q, mosi_s};

  // Frame control: csb framing, bit counting, shift registers and TX loads.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    done_d        = 1'b0;
    rx_overflow_d = 1'b0;
    tx_underrun_d = 1'b0;
    rx_push       = 1'b0;
    tx_pop        = 1'b0;
    tx_load       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (csb_fall) begin
          state_d  = ST_ACTIVE;
          bitcnt_d = '0;
          tx_load  = ~CPHA;  // CPHA=0 must present the MSB before the first edge
        end
      end
      ST_ACTIVE: begin
        if (csb_rise) begin
          state_d = ST_IDLE;
          tx_sr_d = '0;      // partial TX byte is abandoned and miso parks low
        end else begin
          if (sample_edge) begin
            rx_sr_d  = rx_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              done_d = 1'b1;
              if (bus.rx_en) begin
                rx_push       = ~rx_full;
                rx_overflow_d = rx_full;
              end
            end
          end
          // bitcnt==0 on a shift edge marks a byte boundary in both phases.
          if (shift_edge) begin
            if (bitcnt_q == 3'd0) tx_load = 1'b1;
            else                  tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_load) begin
      if (tx_empty) begin
        tx_sr_d       = 8'hFF;
        tx_underrun_d = 1'b1;
      end else begin
        tx_sr_d = tx_mem_q[tx_rptr_q];
        tx_pop  = 1'b1;
      end
    end

    busy_d    = (state_d == ST_ACTIVE);
    miso_oe_d = (state_d == ST_ACTIVE);
  end

  // FIFO pointers and levels; flush wins over any same-cycle push or pop.
  always_comb begin
    tx_wr_ok = bus.wr & ~tx_full;
    rx_rd_ok = bus.rd & ~rx_empty;

    rx_wptr_d  = rx_wptr_q + (rx_push ? PTR_ONE : '0);
    rx_rptr_d  = rx_rptr_q + (rx_rd_ok ? PTR_ONE : '0);
    rx_level_d = rx_level_q + (FAW+1)'(rx_push) - (FAW+1)'(rx_rd_ok);
    if (bus.rx_flush) begin
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_level_d = '0;
    end

    tx_wptr_d  = tx_wptr_q + (tx_wr_ok ? PTR_ONE : '0);
    tx_rptr_d  = tx_rptr_q + (tx_pop ? PTR_ONE : '0);
    tx_level_d = tx_level_q + (FAW+1)'(tx_wr_ok) - (FAW+1)'(tx_pop);
    if (bus.tx_flush) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_level_d = '0;
    end
  end

  // Control and FIFO bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      busy_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      done_q        <= 1'b0;
      rx_overflow_q <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      rx_level_q    <= '0;
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_level_q    <= '0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      busy_q        <= busy_d;
      miso_oe_q     <= miso_oe_d;
      done_q        <= done_d;
      rx_overflow_q <= rx_overflow_d;
      tx_underrun_q <= tx_underrun_d;
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      rx_level_q    <= rx_level_d;
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      tx_level_q    <= tx_level_d;
    end
  end

  // FIFO storage writes.
  // NOTE: the storage arrays are not reset; the zeroed levels make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (rx_push && !bus.rx_flush)  rx_mem_q[rx_wptr_q] <= rx_byte;
    if (tx_wr_ok && !bus.tx_flush) tx_mem_q[tx_wptr_q] <= bus.datai;
  end

  assign miso            = tx_sr_q[7];
  assign miso_oe         = miso_oe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rx_overflow = rx_overflow_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.rx_level    = rx_level_q;
  assign bus.tx_level    = tx_level_q;
  assign bus.datao       = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
  assign bus.rx_above    = (rx_level_q > {1'b0, bus.rx_threshold});
  assign bus.tx_below    = (tx_level_q < {1'b0, bus.tx_threshold});
endmodule

// File: tb/tb_ef_spi_target.sv
// tb_ef_spi_target: drives ef_spi_target as an SPI controller with a scoreboard
// of expected RX/TX bytes, a threshold vector table and hand-written corner cases.
module tb_ef_spi_target;
  localparam int FAW = 4;
  localparam int H   = 10;  // sclk half-period in clk cycles

  logic clk = 1'b0;
  logic rst, cpol, cpha, sclk, csb, mosi;
  logic miso, miso_oe;

  ef_spi_target_if #(.FAW(FAW)) bus ();

  ef_spi_target #(.FAW(FAW)) dut (
    .clk     (clk),
    .rst     (rst),
    .CPOL    (cpol),
    .CPHA    (cpha),
    .sclk    (sclk),
    .csb     (csb),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int ovf_cnt  = 0;
  int unr_cnt  = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  typedef struct {
    int         n_wr;
    logic [3:0] thr;
    logic [4:0] exp_level;
    logic       exp_below;
  } thr_vec_t;

  typedef struct {
    logic cpol;
    logic cpha;
  } mode_t;

  // Pulse counters for the one-cycle status outputs.
  always @(negedge clk) begin
    if (bus.done)        done_cnt <= done_cnt + 1;
    if (bus.rx_overflow) ovf_cnt  <= ovf_cnt + 1;
    if (bus.tx_underrun) unr_cnt  <= unr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    tick(H);
  endtask

  task automatic frame_begin();
    csb = 1'b0;
    tick(H);
  endtask

  task automatic frame_end();
    tick(H);
    csb = 1'b1;
    tick(H);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi = b[7-i];
        tick(H);
        sclk = ~cpol;
        r[7-i] = miso;
        tick(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = b[7-i];
        tick(H);
        sclk = cpol;
        r[7-i] = miso;
        tick(H);
      end
    end
  endtask

  task automatic tx_write(input logic [7:0] b);
    bus.wr    = 1'b1;
    bus.datai = b;
    tick(1);
    bus.wr    = 1'b0;
  endtask

  task automatic drain_rx(input string name);
    while (exp_rx.size() > 0) begin
      check({name, "_datao"}, bus.datao, exp_rx.pop_front());
      bus.rd = 1'b1;
      tick(1);
      bus.rd = 1'b0;
    end
    check({name, "_empty_level"}, bus.rx_level, 0);
    check({name, "_empty_datao"}, bus.datao, 0);
  endtask

  initial begin
    thr_vec_t   tv[8];
    mode_t      modes[4];
    logic [7:0] r, b;
    int         d0, o0, u0;

    tv[0] = '{0,  4'd0,  5'd0,  1'b0};
    tv[1] = '{0,  4'd3,  5'd0,  1'b1};
    tv[2] = '{2,  4'd3,  5'd2,  1'b1};
    tv[3] = '{3,  4'd3,  5'd3,  1'b0};
    tv[4] = '{5,  4'd3,  5'd5,  1'b0};
    tv[5] = '{14, 4'd15, 5'd14, 1'b1};
    tv[6] = '{16, 4'd15, 5'd16, 1'b0};
    tv[7] = '{17, 4'd15, 5'd16, 1'b0};
    modes[0] = '{1'b0, 1'b0};
    modes[1] = '{1'b0, 1'b1};
    modes[2] = '{1'b1, 1'b0};
    modes[3] = '{1'b1, 1'b1};

    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; csb = 1'b1; mosi = 1'b0;
    bus.wr = 1'b0; bus.datai = '0; bus.rd = 1'b0; bus.rx_en = 1'b0;
    bus.rx_flush = 1'b0; bus.tx_flush = 1'b0;
    bus.rx_threshold = '0; bus.tx_threshold = '0;
    tick(5);
    rst = 1'b0;
    tick(2);

    // Reset state
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_overflow", bus.rx_overflow, 0);
    check("rst_underrun", bus.tx_underrun, 0);
    check("rst_rx_level", bus.rx_level, 0);
    check("rst_tx_level", bus.tx_level, 0);
    check("rst_datao", bus.datao, 0);
    check("rst_rx_above", bus.rx_above, 0);
    check("rst_tx_below_thr0", bus.tx_below, 0);
    bus.tx_threshold = 4'd3;
    tick(1);
    check("rst_tx_below_thr3", bus.tx_below, 1);

    // TX level / threshold vector table
    foreach (tv[k]) begin
      bus.tx_flush = 1'b1;
      tick(1);
      bus.tx_flush = 1'b0;
      bus.tx_threshold = tv[k].thr;
      for (int j = 0; j < tv[k].n_wr; j++) tx_write(8'(j));
      tick(1);
      check($sformatf("tbl%0d_tx_level", k), bus.tx_level, 32'(tv[k].exp_level));
      check($sformatf("tbl%0d_tx_below", k), bus.tx_below, 32'(tv[k].exp_below));
    end
    bus.tx_flush = 1'b1;
    tick(1);
    bus.tx_flush = 1'b0;

    // Mode 0 receive
    set_mode(1'b0, 1'b0);
    bus.rx_en = 1'b1;
    bus.rx_threshold = 4'd1;
    d0 = done_cnt;
    frame_begin();
    spi_bits(8'h35, 8, r); exp_rx.push_back(8'h35);
    spi_bits(8'h93, 8, r); exp_rx.push_back(8'h93);
    frame_end();
    check("m0rx_level", bus.rx_level, 2);
    check("m0rx_done_pulses", done_cnt - d0, 2);
    check("m0rx_above", bus.rx_above, 1);
    drain_rx("m0rx");

    // Transmit in all four modes
    bus.rx_en = 1'b0;
    foreach (modes[m]) begin
      set_mode(modes[m].cpol, modes[m].cpha);
      bus.tx_flush = 1'b1;
      tick(1);
      bus.tx_flush = 1'b0;
      tx_write(8'hA5); exp_tx.push_back(8'hA5);
      tx_write(8'h3C); exp_tx.push_back(8'h3C);
      tick(1);
      check($sformatf("tx_mode%0d_level_pre", m), bus.tx_level, 2);
      u0 = unr_cnt;
      frame_begin();
      check($sformatf("tx_mode%0d_level_start", m), bus.tx_level, cpha ? 2 : 1);
      spi_bits(8'h00, 8, r);
      tick(4);
      check($sformatf("tx_mode%0d_byte0", m), r, exp_tx.pop_front());
      check($sformatf("tx_mode%0d_level_mid", m), bus.tx_level, cpha ? 1 : 0);
      spi_bits(8'h00, 8, r);
      tick(4);
      check($sformatf("tx_mode%0d_byte1", m), r, exp_tx.pop_front());
      check($sformatf("tx_mode%0d_level_end", m), bus.tx_level, 0);
      frame_end();
      check($sformatf("tx_mode%0d_underruns", m), unr_cnt - u0, cpha ? 0 : 1);
      check($sformatf("tx_mode%0d_idle_busy", m), bus.busy, 0);
      check($sformatf("tx_mode%0d_idle_miso", m), miso, 0);
      check($sformatf("tx_mode%0d_rx_dropped", m), bus.rx_level, 0);
    end

    // Underrun: one byte from an empty TX FIFO (mode 1, single load per byte)
    set_mode(1'b0, 1'b1);
    u0 = unr_cnt;
    frame_begin();
    spi_bits(8'h00, 8, r);
    frame_end();
    check("underrun_data", r, 8'hFF);
    check("underrun_pulses", unr_cnt - u0, 1);

    // Overflow: 17 bytes without reading
    set_mode(1'b0, 1'b0);
    bus.rx_en = 1'b1;
    bus.rx_threshold = 4'd15;
    d0 = done_cnt;
    o0 = ovf_cnt;
    frame_begin();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 16) exp_rx.push_back(b);
      spi_bits(b, 8, r);
    end
    frame_end();
    check("ovf_level", bus.rx_level, 16);
    check("ovf_pulses", ovf_cnt - o0, 1);
    check("ovf_done_pulses", done_cnt - d0, 17);
    check("ovf_above", bus.rx_above, 1);
    check("ovf_first_byte", bus.datao, exp_rx[0]);
    drain_rx("ovf");

    // Abort after 5 bits, then a full byte
    bus.rx_threshold = 4'd0;
    d0 = done_cnt;
    frame_begin();
    spi_bits(8'hFF, 5, r);
    frame_end();
    check("abort_level", bus.rx_level, 0);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_miso", miso, 0);
    frame_begin();
    spi_bits(8'h6E, 8, r); exp_rx.push_back(8'h6E);
    frame_end();
    check("abort_next_level", bus.rx_level, 1);
    check("abort_next_datao", bus.datao, exp_rx[0]);

    // Reset mid-byte with both FIFOs populated
    bus.tx_threshold = 4'd3;
    tx_write(8'h11);
    tx_write(8'h22);
    frame_begin();
    spi_bits(8'hC4, 4, r);
    check("midrst_busy_before", bus.busy, 1);
    check("midrst_oe_before", miso_oe, 1);
    rst = 1'b1;
    tick(1);
    check("midrst_miso", miso, 0);
    check("midrst_miso_oe", miso_oe, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_overflow", bus.rx_overflow, 0);
    check("midrst_underrun", bus.tx_underrun, 0);
    check("midrst_rx_level", bus.rx_level, 0);
    check("midrst_tx_level", bus.tx_level, 0);
    check("midrst_datao", bus.datao, 0);
    check("midrst_rx_above", bus.rx_above, 0);
    check("midrst_tx_below", bus.tx_below, 1);
    exp_rx.delete();
    rst = 1'b0;
    spi_bits(8'h0F, 4, r);
    frame_end();
    check("midrst_tail_ignored", bus.rx_level, 0);
    check("midrst_tail_busy", bus.busy, 0);
    frame_begin();
    spi_bits(8'hC4, 8, r); exp_rx.push_back(8'hC4);
    frame_end();
    check("midrst_resync_level", bus.rx_level, 1);
    drain_rx("midrst");

    // TX flush with a same-cycle write
    tx_write(8'h01);
    tx_write(8'h02);
    tx_write(8'h03);
    bus.tx_flush = 1'b1;
    bus.wr = 1'b1;
    bus.datai = 8'h77;
    tick(1);
    bus.tx_flush = 1'b0;
    bus.wr = 1'b0;
    check("txflush_level", bus.tx_level, 0);
    check("txflush_below_thr3", bus.tx_below, 1);
    bus.tx_threshold = 4'd0;
    tick(1);
    check("txflush_below_thr0", bus.tx_below, 0);

    // RX flush held across a byte completion, then thresholds on a fresh byte
    d0 = done_cnt;
    bus.rx_flush = 1'b1;
    frame_begin();
    spi_bits(8'h5A, 8, r);
    frame_end();
    bus.rx_flush = 1'b0;
    tick(1);
    check("rxflush_level", bus.rx_level, 0);
    check("rxflush_done", done_cnt - d0, 1);
    check("rxflush_above_thr0", bus.rx_above, 0);
    frame_begin();
    spi_bits(8'h81, 8, r); exp_rx.push_back(8'h81);
    frame_end();
    check("rxthr_level", bus.rx_level, 1);
    check("rxthr_above_thr0", bus.rx_above, 1);
    bus.rx_threshold = 4'd3;
    tick(1);
    check("rxthr_above_thr3", bus.rx_above, 0);
    drain_rx("rxthr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ef_spi_target.md
# ef_spi_target

SPI target (slave) counterpart of the EF_SPI controller: receives frames on `sclk`/`mosi` under `csb` and returns data on `miso`, all in the system `clk` domain, by oversampling the SPI pins. Bytes are MSB-first, 8 bits, and support all four CPOL/CPHA modes. An RX FIFO collects received bytes. A TX FIFO supplies the bytes to send. It sits behind the same bus-wrapper style as EF_SPI and can be looped back against it in simulation.

## Interface
- `FAW`, 4, FIFO address width; each FIFO holds 2^FAW bytes.
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `CPOL` in 1: idle level of `sclk`.
- `CPHA` in 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- `sclk` in 1: SPI clock from the controller. Asynchronous to `clk`.
- `csb` in 1: active-low chip select. Asynchronous.
- `mosi` in 1: serial data in. Asynchronous.
- `miso` out 1: serial data out, equal to `tx_sr[7]`.
- `miso_oe` out 1: output enable; 1 while synchronized `csb` is low.
- `wr` in 1: push `datai` into the TX FIFO.
- `datai` in 8: TX write data.
- `rd` in 1: pop the RX FIFO.
- `datao` out 8: RX FIFO head (show-ahead); 0 when the RX FIFO is empty.
- `rx_en` in 1: enables pushing received bytes.
- `rx_flush` in 1: empties the RX FIFO.
- `tx_flush` in 1: empties the TX FIFO.
- `rx_threshold` in FAW.
- `tx_threshold` in FAW.
- `rx_level` out FAW+1.
- `tx_level` out FAW+1.
- `rx_above` out 1: `rx_level > rx_threshold`.
- `tx_below` out 1: `tx_level < tx_threshold`.
- `busy` out 1: frame active.
- `done` out 1: one-cycle pulse per completed byte.
- `rx_overflow` out 1: one-cycle pulse.
- `tx_underrun` out 1: one-cycle pulse.

## Operation
- **Input path.** `sclk`, `csb` and `mosi` pass through the input stage (see Configuration). A further register on each gives edge detection. The leading edge is the `sclk` transition away from CPOL; the trailing edge is the transition back.
- **States.**
  - IDLE: synchronized `csb` is high.
  - ACTIVE: synchronized `csb` is low.
  - IDLE -> ACTIVE on `csb` fall. This clears `bitcnt` (3 bits) and sets `busy`=1.
  - ACTIVE -> IDLE on `csb` rise from any state. This discards the partial byte (no push, no `done`), and the byte already popped from TX is lost. It also sets `busy`=0 and `miso`=0.
- **Sample edge** (leading if CPHA=0, trailing if CPHA=1): `rx_sr <= {rx_sr[6:0], mosi}` and `bitcnt++`.
  - On the sample with `bitcnt`==7, `bitcnt` wraps to 0 and `done` pulses.
  - The byte is pushed if `rx_en`=1 and the RX FIFO is not full.
  - If `rx_en`=1 and the RX FIFO is full, the byte is dropped and `rx_overflow` pulses.
  - If `rx_en`=0, the byte is silently dropped.
- **Shift edge** (the other edge): `tx_sr <= {tx_sr[6:0], 1'b0}`, except when a load is due.
- **Loads.**
  - CPHA=0: load on `csb` fall, and on the shift edge that follows each byte completion.
  - CPHA=1: load on the leading edge with `bitcnt`==0.
  - A load pops the TX head into `tx_sr`.
  - If the TX FIFO is empty, `tx_sr` <= 8'hFF and `tx_underrun` pulses.
- **FIFOs.**
  - Write when full is ignored, even if a pop occurs in the same cycle.
  - Read when empty is ignored.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the level unchanged.
  - Flush has priority over a same-cycle push or pop and zeroes the level.
  - Levels range 0..2^FAW.
- **Reset.** Everything below is 0:
  - `miso`, `miso_oe`, `busy`, `done`, `rx_overflow`, `tx_underrun`;
  - `rx_level`, `tx_level`, `datao`, `rx_above`;
  - `bitcnt`, `tx_sr`, `rx_sr`.
  - `tx_below` is 1 if `tx_threshold`>0.
  - State returns to IDLE. Reset mid-frame abandons the frame, and the target resynchronizes on the next `csb` fall.

## Timing
- Pin-to-detect latency: 3 `clk` with synchronizers, 2 without.
- `miso` changes 1 `clk` after the detected shift edge or load.
- Push to `rx_level` update: 1 `clk` after the 8th detected sample.
- `done`, `rx_overflow` and `tx_underrun` are coincident with that push cycle.
- `datao` is valid combinationally from the FIFO head the cycle after the push.
- `wr`/`rd` take effect at the next `clk` edge.
- Sustained operation requires each `sclk` half-period to be at least 5 `clk` with synchronizers, or 3 `clk` without.
- `csb` fall to first `sclk` edge must be at least 4 `clk` (CPHA=0 load settles `miso`).

## Configuration
- `EF_SPI_TARGET_SYNC_EN` defined:
  - 2-flop synchronizer on each of `sclk`, `csb` and `mosi`, then the edge register.
  - 3-cycle detect latency; 5-clk minimum half-period.
- Undefined:
  - a single capture register per pin, then the edge register.
  - 2-cycle detect latency; 3-clk minimum half-period.
  - Intended only when the pins are already synchronous to `clk`.
- Functional behaviour is otherwise identical.

## Test plan
- **Mode 0 receive.** CPOL=0, CPHA=0, `rx_en`=1, half-period 10 clk; controller sends 8'h35 then 8'h93. Required: RX FIFO holds 35, 93 in order; `rx_level`=2; two `done` pulses.
- **Transmit, all modes.** TX preloaded with A5, 3C; each of modes 0-3. Required: controller receives A5, 3C MSB-first; `tx_level` goes 2 -> 1 -> 0.
- **Underrun.** TX FIFO empty, one byte clocked. Required: `miso` shifts FF; `tx_underrun` pulses once.
- **Overflow.** 17 bytes received without `rd` (FAW=4). Required: `rx_level`=16; `rx_overflow` pulses once; `datao` = first byte.
- **Abort and reset.** `csb` raised after 5 bits, then byte 8'h6E sent. Required: no push for the partial byte; 6E received intact. Repeat with `rst` asserted mid-byte: all outputs at reset values the next cycle.
- **Flush and thresholds.** Flush while pushing, with thresholds 0 and 3. Required: level reads 0 the cycle after flush; `rx_above` and `tx_below` track level vs threshold.
